uart_wb_host: RTL

Wishbone initiator that drives the 16550-compatible UART core's slave register port (8-bit data bus, 3-bit address) so that the tile can use the UART without an external bus master. After reset it programs the baud divisor and line format. It then continuously polls the Line Status Register to move bytes between a streaming byte interface and the UART's THR/RBR. It sits between the tile's user logic and the UART core, on the same clock and reset.

---
 rtl/uart_wb_host.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - Wishbone initiator that programs a 16550 UART and bridges bytes to/from it
// Optional bus timeout: define UART_WBM_TIMEOUT_EN.
module uart_wb_host #(
   parameter logic [15:0] DIVISOR = 16'd27
`ifdef UART_WBM_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   output logic [2:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   output logic       wb_cyc_o,
   output logic [3:0] wb_sel_o,
   input  logic       wb_ack_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       init_done_o,
   output logic       err_o
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_POLL, S_RD_RBR, S_WR_THR} state_t;

   state_t     state, state_nxt;
   logic [2:0] step;
   logic       bus_gap;
   logic       ack_ok, to_hit, bus_done;
   logic       bus_state;
   logic [2:0] cmd_adr;
   logic [7:0] cmd_dat;
   logic       cmd_we;

   assign ack_ok   = wb_stb_o && wb_ack_i;
   assign bus_done = ack_ok || to_hit;

`ifdef UART_WBM_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        err_q;

   // Counter idles at zero while the strobe is low, so each transaction starts fresh.
   assign to_hit = wb_stb_o && !wb_ack_i && (to_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (!wb_stb_o)
            to_cnt <= '0;
         else if (!wb_ack_i)
            to_cnt <= to_cnt + 16'd1;
         if (to_hit)
            err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign to_hit = 1'b0;
   assign err_o  = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         state <= S_INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:   if (bus_done && step == 3'd5) state_nxt = S_IDLE;
         S_IDLE:   if (!rx_valid_o || tx_valid_i) state_nxt = S_POLL;
         S_POLL: begin
            // RX is checked first so received data is never starved by a busy transmitter.
            if (bus_done) begin
               if (ack_ok && wb_dat_i[0] && !rx_valid_o)
                  state_nxt = S_RD_RBR;
               else if (ack_ok && wb_dat_i[5] && tx_valid_i)
                  state_nxt = S_WR_THR;
               else
                  state_nxt = S_IDLE;
            end
         end
         S_RD_RBR: if (bus_done) state_nxt = S_IDLE;
         S_WR_THR: if (bus_done) state_nxt = S_IDLE;
         default:  state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      bus_state = 1'b1;
      cmd_adr   = 3'd0;
      cmd_dat   = 8'h00;
      cmd_we    = 1'b0;
      case (state)
         S_INIT: begin
            cmd_we = 1'b1;
            case (step)
               3'd0:    begin cmd_adr = 3'd3; cmd_dat = 8'h83;          end
               3'd1:    begin cmd_adr = 3'd0; cmd_dat = DIVISOR[7:0];  end
               3'd2:    begin cmd_adr = 3'd1; cmd_dat = DIVISOR[15:8]; end
               3'd3:    begin cmd_adr = 3'd3; cmd_dat = 8'h03;          end
               3'd4:    begin cmd_adr = 3'd2; cmd_dat = 8'h07;          end
               default: begin cmd_adr = 3'd1; cmd_dat = 8'h00;          end
            endcase
         end
         S_POLL:   cmd_adr = 3'd5;
         S_RD_RBR: cmd_adr = 3'd0;
         S_WR_THR: begin
            cmd_we  = 1'b1;
            cmd_dat = tx_data_i;
         end
         default:  bus_state = 1'b0;
      endcase
   end

   // bus_gap holds off a new strobe for one cycle after every completion.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_stb_o <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_sel_o <= 4'b0000;
         wb_adr_o <= 3'd0;
         wb_dat_o <= 8'h00;
         wb_we_o  <= 1'b0;
         bus_gap  <= 1'b0;
      end else begin
         bus_gap <= bus_done;
         if (bus_done) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_sel_o <= 4'b0000;
         end else if (bus_state && !wb_stb_o && !bus_gap) begin
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_sel_o <= 4'b0001;
            wb_adr_o <= cmd_adr;
            wb_dat_o <= cmd_dat;
            wb_we_o  <= cmd_we;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         step        <= 3'd0;
         init_done_o <= 1'b0;
         tx_ready_o  <= 1'b0;
         rx_data_o   <= 8'h00;
         rx_valid_o  <= 1'b0;
      end else begin
         tx_ready_o <= (state == S_WR_THR) && ack_ok;
         if (state == S_INIT && bus_done) begin
            step <= step + 3'd1;
            if (step == 3'd5)
               init_done_o <= 1'b1;
         end
         if (state == S_RD_RBR && ack_ok) begin
            rx_data_o  <= wb_dat_i;
            rx_valid_o <= 1'b1;
         end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
      end
   end

endmodule
